// File: rtl/led_seq_pkg.sv
// Shared types and constants for the four-LED running-light sequencer.
// Mode encodings, initial patterns and the bounce direction encoding live here.
package led_seq_pkg;

    localparam int LED_W   = 4;
    localparam int SPEED_W = 2;

    typedef enum logic [1:0] {
        MODE_SHL    = 2'd0,
        MODE_SHR    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    localparam logic [LED_W-1:0] INIT_SHL    = 4'b0001;
    localparam logic [LED_W-1:0] INIT_SHR    = 4'b1000;
    localparam logic [LED_W-1:0] INIT_BOUNCE = 4'b0001;
    localparam logic [LED_W-1:0] INIT_BLINK  = 4'b1111;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    function automatic logic [LED_W-1:0] init_pattern(input mode_e m);
        logic [LED_W-1:0] p;
        case (m)
            MODE_SHL:    p = INIT_SHL;
            MODE_SHR:    p = INIT_SHR;
            MODE_BOUNCE: p = INIT_BOUNCE;
            MODE_BLINK:  p = INIT_BLINK;
            default:     p = INIT_SHL;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_step_divider.sv
// Step-rate divider: counts enabled cycles and flags the terminal count of a
// period equal to BASE_DIV >> shamt. A clear restarts the period from zero.
module step_divider
    import led_seq_pkg::*;
#(
    parameter int BASE_DIV = 50_000_000,
    parameter int CNT_W    = $clog2(BASE_DIV)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [SPEED_W-1:0] shamt,
    output logic               tick
);

    // One extra bit so a power-of-two BASE_DIV is representable before the -1.
    localparam logic [CNT_W:0] BASE_FULL = (CNT_W+1)'(BASE_DIV);
    localparam logic [CNT_W:0] ONE_FULL  = (CNT_W+1)'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   period_m1;
    logic             tc;

    always_comb begin
        period_m1 = (BASE_FULL >> shamt) - ONE_FULL;
        tc        = ({1'b0, cnt_q} == period_m1);
        tick      = en && !clr && tc;
        cnt_d     = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Four-LED running-light sequencer: owns mode, speed, bounce direction and the
// LED register, stepping the pattern on each divider terminal count.
//
//   state (mode)  | meaning
//   MODE_SHL      | rotate left  0001->0010->0100->1000->0001
//   MODE_SHR      | rotate right 1000->0100->0010->0001->1000
//   MODE_BOUNCE   | walk up to 1000 then back down to 0001, no repeat at ends
//   MODE_BLINK    | all LEDs toggle 1111<->0000
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int BASE_DIV = 50_000_000,
    parameter int CNT_W    = $clog2(BASE_DIV)
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               mode_next,
    input  logic               speed_next,
    input  logic               pause,
    output logic [LED_W-1:0]   led,
    output logic               step_tick,
    output logic [1:0]         mode,
    output logic [SPEED_W-1:0] speed
);

    mode_e              mode_q, mode_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               dir_q, dir_d;
    logic               step_tick_q, step_tick_d;
    logic               key_clr;
    logic               tick;

    // Any key press restarts the step period; the divider masks tick on a clear.
    assign key_clr = mode_next || speed_next;

    step_divider #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (CNT_W)
    ) u_step_divider (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .en    (!pause),
        .clr   (key_clr),
        .shamt (speed_q),
        .tick  (tick)
    );

    always_comb begin
        mode_d      = mode_q;
        speed_d     = speed_q;
        led_d       = led_q;
        dir_d       = dir_q;
        step_tick_d = tick;

        if (speed_next) begin
            speed_d = speed_q + SPEED_W'(1);
        end

        if (mode_next) begin
            mode_d = mode_e'(mode_q + 2'd1);
            led_d  = init_pattern(mode_d);
            dir_d  = DIR_UP;
        end else if (tick) begin
            case (mode_q)
                MODE_SHL:    led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                MODE_SHR:    led_d = {led_q[0], led_q[LED_W-1:1]};
                MODE_BOUNCE: begin
                    // Direction flips on arrival at an end so the end value shows once.
                    if (dir_q == DIR_UP) begin
                        led_d = {led_q[LED_W-2:0], 1'b0};
                        if (led_d[LED_W-1]) dir_d = DIR_DOWN;
                    end else begin
                        led_d = {1'b0, led_q[LED_W-1:1]};
                        if (led_d[0]) dir_d = DIR_UP;
                    end
                end
                MODE_BLINK:  led_d = ~led_q;
                default:     led_d = led_q;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q      <= MODE_SHL;
            speed_q     <= '0;
            led_q       <= INIT_SHL;
            dir_q       <= DIR_UP;
            step_tick_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            speed_q     <= speed_d;
            led_q       <= led_d;
            dir_q       <= dir_d;
            step_tick_q <= step_tick_d;
        end
    end

    assign led       = led_q;
    assign step_tick = step_tick_q;
    assign mode      = mode_q;
    assign speed     = speed_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer at BASE_DIV = 16: directed scenarios followed
// by random key/pause/reset traffic, all compared against a pattern-table model.
module tb_led_pattern_sequencer;

    localparam int BASE_DIV = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       mode_next = 1'b0;
    logic       speed_next = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] led;
    logic       step_tick;
    logic [1:0] mode;
    logic [1:0] speed;

    led_pattern_sequencer #(.BASE_DIV(BASE_DIV)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .mode_next  (mode_next),
        .speed_next (speed_next),
        .pause      (pause),
        .led        (led),
        .step_tick  (step_tick),
        .mode       (mode),
        .speed      (speed)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Model: mode, speed, index into the mode's pattern list, active cycles since last step/clear.
    int m_mode = 0, m_speed = 0, m_k = 0, m_el = 0;
    bit m_tick = 1'b0;

    int cyc_no = 0;
    int last_tick = 0;
    int gap = 0;
    int tick_cnt = 0;
    int mark = 0;

    function automatic logic [3:0] pat(input int md, input int k);
        logic [3:0] p;
        case (md)
            0: case (k) 0: p = 4'b0001; 1: p = 4'b0010; 2: p = 4'b0100; default: p = 4'b1000; endcase
            1: case (k) 0: p = 4'b1000; 1: p = 4'b0100; 2: p = 4'b0010; default: p = 4'b0001; endcase
            2: case (k) 0: p = 4'b0001; 1: p = 4'b0010; 2: p = 4'b0100; 3: p = 4'b1000;
                        4: p = 4'b0100; default: p = 4'b0010; endcase
            default: p = (k == 0) ? 4'b1111 : 4'b0000;
        endcase
        return p;
    endfunction

    function automatic int plen(input int md);
        return (md == 2) ? 6 : (md == 3) ? 2 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_no);
        end
    endtask

    task automatic cyc(input bit r, input bit mn, input bit sn, input bit pz);
        sys_rst    = r;
        mode_next  = mn;
        speed_next = sn;
        pause      = pz;
        @(posedge sys_clk);
        cyc_no++;
        m_tick = 1'b0;
        if (r) begin
            m_mode = 0; m_speed = 0; m_k = 0; m_el = 0;
        end else if (mn || sn) begin
            if (mn) begin m_mode = (m_mode + 1) % 4; m_k = 0; end
            if (sn) m_speed = (m_speed + 1) % 4;
            m_el = 0;
        end else if (!pz) begin
            if (m_el == (BASE_DIV >> m_speed) - 1) begin
                m_el = 0;
                m_tick = 1'b1;
                m_k = (m_k + 1) % plen(m_mode);
            end else begin
                m_el++;
            end
        end
        #1;
        chk("led", 32'(led), 32'(pat(m_mode, m_k)));
        chk("step_tick", 32'(step_tick), 32'(m_tick));
        chk("mode", 32'(mode), 32'(m_mode));
        chk("speed", 32'(speed), 32'(m_speed));
        if (step_tick === 1'b1) begin
            gap = cyc_no - last_tick;
            last_tick = cyc_no;
            tick_cnt++;
        end
        if (r) last_tick = cyc_no;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_tick(input string tag);
        for (int i = 0; i < 64; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (step_tick === 1'b1) break;
        end
        chk({tag, "_seen"}, 32'(step_tick), 32'd1);
    endtask

    initial begin
        bit pz_lvl;

        // Reset
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_led", 32'(led), 32'h1);
        chk("rst_tick", 32'(step_tick), 32'h0);

        // Mode 0 free-run: ticks at 16, 32, 48, 64, 80
        tick_cnt = 0;
        idle(80);
        chk("ticks_in_80", 32'(tick_cnt), 32'd5);
        chk("period_16", 32'(gap), 32'd16);

        // SHR then BOUNCE, then 8 bounce steps
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("shr_init", 32'(led), 32'h8);
        idle(5);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("bounce_mode", 32'(mode), 32'd2);
        chk("bounce_init", 32'(led), 32'h1);
        idle(8 * 16);

        // Speed up three times: period 2; fourth press back to 16
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            idle(3);
        end
        idle(20);
        chk("period_2", 32'(gap), 32'd2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("speed_wrap", 32'(speed), 32'd0);
        idle(40);
        chk("period_16_again", 32'(gap), 32'd16);

        // speed_next on the terminal-count cycle: key wins, no step
        for (int i = 0; i < 32 && m_el != 15; i++) idle(1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("tc_key_no_tick", 32'(step_tick), 32'd0);
        mark = cyc_no;
        wait_tick("after_tc_key");
        chk("clr_to_tick", 32'(cyc_no - mark), 32'd8);

        // Back to speed 0, then pause 10 cycles starting at cnt = 5
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        wait_tick("pre_pause");
        for (int i = 0; i < 16 && m_el != 5; i++) idle(1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            chk("pause_no_tick", 32'(step_tick), 32'd0);
        end
        wait_tick("post_pause");
        chk("pause_gap", 32'(gap), 32'd26);

        // Blink, then simultaneous mode_next + speed_next
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("blink_init", 32'(led), 32'hF);
        idle(40);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("both_mode", 32'(mode), 32'd0);
        chk("both_led", 32'(led), 32'h1);
        chk("both_speed", 32'(speed), 32'd1);
        mark = cyc_no;
        wait_tick("after_both");
        chk("both_clr_to_tick", 32'(cyc_no - mark), 32'd8);

        // Mode 2 at speed 2, reset mid-sequence with other inputs active
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        idle(23);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("midrst_led", 32'(led), 32'h1);
        chk("midrst_mode", 32'(mode), 32'd0);
        chk("midrst_speed", 32'(speed), 32'd0);
        wait_tick("after_midrst");
        chk("midrst_gap", 32'(gap), 32'd16);

        // Random traffic
        pz_lvl = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) pz_lvl = ~pz_lvl;
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 39) == 0,
                pz_lvl);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc_no);
        $fatal(1, "watchdog");
    end

endmodule
